// File: rtl/lcd_req_sched_if.sv
// Requester-side bundle of the LCD request scheduler.
//   req_valid  [1:0]  per-requester request, held with its command until accepted
//   req_cmd0   [2:0]  requester 0 command
//   req_cmd1   [2:0]  requester 1 command
//   req_ready  [1:0]  one-hot accept pulse from the scheduler (combinational)
//   rsp_valid         returned pixel valid
//   rsp_data   [7:0]  returned pixel
//   rsp_id            requester that owns rsp_data
//   rsp_last          marks the 16th pixel of a burst
// master: requester side; slave: scheduler side.
interface lcd_req_sched_if;
  logic [1:0] req_valid;
  logic [2:0] req_cmd0;
  logic [2:0] req_cmd1;
  logic [1:0] req_ready;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_id;
  logic       rsp_last;

  modport master (
    output req_valid, req_cmd0, req_cmd1,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_last
  );

  modport slave (
    input  req_valid, req_cmd0, req_cmd1,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_last
  );
endinterface

// File: rtl/lcd_req_sched.sv
// Shares one LCD_CTRL-style display engine between two requesters.
// Round-robin arbitration, one 3-bit command in flight at a time. A LOAD
// streams 64 image bytes from the image memory into the engine; every
// command ends with a 16-pixel output burst that is returned to the owner.
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   bus (slave)       requester handshake and response stream
//   img_addr  [6:0]   image memory address {id, idx}; memory has 1-cycle read latency
//   img_rdata [7:0]   image memory read data
//   lcd_cmd   [2:0]   command to the engine
//   lcd_cmd_valid     command strobe, issue cycle only (combinational)
//   lcd_datain [7:0]  pixel to engine during LOAD (image read data)
//   lcd_dataout [7:0] engine pixel output
//   lcd_output_valid  engine pixel qualifier
//   lcd_busy          engine busy
//   err_timeout       sticky: command did not finish within TIMEOUT cycles
//   err_count         sticky: burst length was not 16
module lcd_req_sched #(
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             reset,
  lcd_req_sched_if.slave   bus,
  output logic [6:0]       img_addr,
  input  logic [7:0]       img_rdata,
  output logic [2:0]       lcd_cmd,
  output logic             lcd_cmd_valid,
  output logic [7:0]       lcd_datain,
  input  logic [7:0]       lcd_dataout,
  input  logic             lcd_output_valid,
  input  logic             lcd_busy,
  output logic             err_timeout,
  output logic             err_count
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE} state_t;

  state_t     state, state_nxt;
  logic       last_grant;
  logic       id;
  logic [6:0] idx;
  logic [7:0] timer;
  logic [4:0] pcnt;

  logic       grant;
  logic       gsel;
  logic [2:0] gcmd;
  logic       fwd;
  logic [4:0] pcnt_inc;
  logic       timeout_hit;
  logic       done_hit;

  // Pixel counter saturates so a runaway engine cannot wrap back to 16.
  function automatic logic [4:0] sat_inc5(input logic [4:0] v, input logic en);
    if (en && (v != 5'd31)) return v + 5'd1;
    return v;
  endfunction

  always_comb begin
    state_nxt     = state;
    bus.req_ready = 2'b00;
    lcd_cmd_valid = 1'b0;
    lcd_cmd       = 3'd0;
    img_addr      = 7'd0;
    lcd_datain    = 8'd0;

    // Sole requester wins; on a tie the one not granted last time wins.
    gsel = (bus.req_valid == 2'b10) ? 1'b1 :
           (bus.req_valid == 2'b01) ? 1'b0 : ~last_grant;
    gcmd  = gsel ? bus.req_cmd1 : bus.req_cmd0;
    grant = (state == IDLE) && !reset && !lcd_busy && (bus.req_valid != 2'b00);

    fwd         = (state != IDLE) && lcd_output_valid;
    pcnt_inc    = sat_inc5(pcnt, fwd);
    timeout_hit = (state != IDLE) && (timer == 8'(TIMEOUT - 1));
    // Engine raises busy the cycle after issue, so busy low only counts from
    // the second cycle after issue (timer != 0).
    done_hit    = (state == WAIT_DONE) && !lcd_busy && (timer != 8'd0);

    case (state)
      IDLE: begin
        if (grant) begin
          bus.req_ready = gsel ? 2'b10 : 2'b01;
          lcd_cmd_valid = 1'b1;
          lcd_cmd       = gcmd;
          if (gcmd == 3'd1) begin
            // First read issued with the command so byte 0 lands in cycle 1.
            img_addr  = {gsel, 6'd0};
            state_nxt = LOAD;
          end else begin
            state_nxt = WAIT_DONE;
          end
        end
      end
      LOAD: begin
        img_addr   = {id, idx[5:0]};
        lcd_datain = img_rdata;
        if (idx == 7'd64) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (timeout_hit) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      id            <= 1'b0;
      idx           <= 7'd0;
      timer         <= 8'd0;
      pcnt          <= 5'd0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= 8'd0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_last  <= 1'b0;
      err_timeout   <= 1'b0;
      err_count     <= 1'b0;
    end else begin
      state <= state_nxt;

      if (grant) begin
        id         <= gsel;
        last_grant <= gsel;
        timer      <= 8'd0;
        idx        <= 7'd1;
      end else if (state != IDLE) begin
        timer <= timer + 8'd1;
      end

      if ((state == LOAD) && (idx <= 7'd63)) idx <= idx + 7'd1;

      // Response stage: engine pixel -> registered response.
      bus.rsp_valid <= fwd;
      bus.rsp_last  <= fwd && (pcnt == 5'd15);
      if (fwd) begin
        bus.rsp_data <= lcd_dataout;
        bus.rsp_id   <= id;
      end

      if ((state != IDLE) && (state_nxt == IDLE)) pcnt <= 5'd0;
      else                                        pcnt <= pcnt_inc;

      if (fwd && (pcnt >= 5'd16)) err_count <= 1'b1;
      if (timeout_hit) err_timeout <= 1'b1;
      else if (done_hit && (pcnt_inc != 5'd16)) err_count <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_req_sched.sv
// Bench for lcd_req_sched: image memory model, simplified display engine
// model, transaction-level reference of the scheduler, directed scenarios
// and a randomized two-requester phase.
module tb_lcd_req_sched;
  localparam int TIMEOUT = 200;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lcd_req_sched_if bus();
  logic [6:0] img_addr;
  logic [7:0] img_rdata;
  logic [2:0] lcd_cmd;
  logic       lcd_cmd_valid;
  logic [7:0] lcd_datain;
  logic [7:0] lcd_dataout;
  logic       lcd_output_valid;
  logic       lcd_busy;
  logic       err_timeout;
  logic       err_count;

  lcd_req_sched #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .img_addr(img_addr), .img_rdata(img_rdata),
    .lcd_cmd(lcd_cmd), .lcd_cmd_valid(lcd_cmd_valid), .lcd_datain(lcd_datain),
    .lcd_dataout(lcd_dataout), .lcd_output_valid(lcd_output_valid), .lcd_busy(lcd_busy),
    .err_timeout(err_timeout), .err_count(err_count)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Image memory, 1-cycle read latency.
  logic [7:0] mem [128];
  always @(posedge clk) img_rdata <= mem[img_addr];

  // Display engine model: 8x8 image, fit view samples odd rows/cols,
  // zoom view is a 4x4 window centred on (ex,ey).
  int   emode = 0;  // 0 normal, 1 hang (busy long past timeout), 2 emit 15 pixels
  int   ephase, ek, ej, enpix, ehold, ex, ey;
  logic ezoom;
  logic [7:0] eimg [64];

  function automatic logic [7:0] epix(input int j);
    int r, c, a;
    r = j / 4;
    c = j % 4;
    if (ezoom) a = (ey - 2 + r) * 8 + (ex - 2 + c);
    else       a = (2 * r + 1) * 8 + (2 * c + 1);
    return eimg[a];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ephase <= 0; lcd_busy <= 1'b0; lcd_output_valid <= 1'b0; lcd_dataout <= 8'd0;
      ezoom <= 1'b0; ex <= 4; ey <= 4; ek <= 0; ej <= 0; enpix <= 16; ehold <= 0;
    end else begin
      lcd_output_valid <= 1'b0;
      case (ephase)
        0: if (lcd_cmd_valid) begin
          lcd_busy <= 1'b1; ej <= 0; ek <= 0; ehold <= 0;
          enpix <= (emode == 2) ? 15 : 16;
          case (lcd_cmd)
            3'd1: begin ezoom <= 1'b0; ex <= 4; ey <= 4; end
            3'd2: if (!ezoom) begin ezoom <= 1'b1; ex <= 4; ey <= 4; end
            3'd3: begin ezoom <= 1'b0; ex <= 4; ey <= 4; end
            3'd4: if (ezoom && ex < 6) ex <= ex + 1;
            3'd5: if (ezoom && ex > 2) ex <= ex - 1;
            3'd6: if (ezoom && ey > 2) ey <= ey - 1;
            3'd7: if (ezoom && ey < 6) ey <= ey + 1;
            default: ;
          endcase
          ephase <= (emode == 1) ? 4 : (lcd_cmd == 3'd1) ? 1 : 3;
        end
        1: begin
          eimg[ek] <= lcd_datain;
          ek <= ek + 1;
          if (ek == 63) ephase <= 3;
        end
        3: if ($urandom % 4 != 0) begin
          lcd_output_valid <= 1'b1;
          lcd_dataout <= epix(ej);
          ej <= ej + 1;
          if (ej == enpix - 1) ephase <= 5;
        end
        4: begin
          ehold <= ehold + 1;
          if (ehold == TIMEOUT + 30) begin lcd_busy <= 1'b0; ephase <= 0; end
        end
        5: begin lcd_busy <= 1'b0; ephase <= 0; end
        default: ephase <= 0;
      endcase
    end
  end

  // Reference model, transaction level: one command in flight with its
  // issue cycle, owner, kind and pixel count; expected registered outputs.
  bit   m_active = 0, m_id = 0, m_last = 1, m_load = 0;
  int   m_issue = 0, m_pix = 0;
  logic e_rv = 0, e_rid = 0, e_rl = 0, e_tmo = 0, e_cnt = 0;
  logic [7:0] e_rd = 0;
  logic [1:0] rv;
  bit   gr, g;
  logic [2:0] cmdg;
  int   age;
  logic [1:0] acc_prev = 2'b00;
  logic [7:0] rq_d[$];
  bit   rq_id[$];
  bit   rq_l[$];
  bit   gq[$];

  initial forever begin
    @(negedge clk);
    cyc++;
    acc_prev = bus.req_valid & bus.req_ready;
    if (reset) begin
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_cmd_valid", lcd_cmd_valid, 0);
      chk("rst_cmd", lcd_cmd, 0);
      chk("rst_img_addr", img_addr, 0);
      chk("rst_datain", lcd_datain, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
      chk("rst_rsp_id", bus.rsp_id, 0);
      chk("rst_rsp_last", bus.rsp_last, 0);
      chk("rst_err_timeout", err_timeout, 0);
      chk("rst_err_count", err_count, 0);
      m_active = 0; m_last = 1; m_pix = 0;
      e_rv = 0; e_rd = 0; e_rid = 0; e_rl = 0; e_tmo = 0; e_cnt = 0;
    end else begin
      rv   = bus.req_valid;
      gr   = !m_active && !lcd_busy && (rv != 2'b00);
      g    = (rv == 2'b10) ? 1'b1 : (rv == 2'b01) ? 1'b0 : !m_last;
      cmdg = g ? bus.req_cmd1 : bus.req_cmd0;
      chk("req_ready", bus.req_ready, gr ? (g ? 2'b10 : 2'b01) : 2'b00);
      chk("cmd_valid", lcd_cmd_valid, gr);
      if (gr) begin
        chk("cmd", lcd_cmd, cmdg);
        if (cmdg == 3'd1) chk("load_addr0", img_addr, {g, 6'd0});
        gq.push_back(g);
      end
      if (m_active && m_load) begin
        age = cyc - m_issue;
        if (age <= 63) chk("load_addr", img_addr, m_id * 64 + age);
        if (age <= 64) chk("load_datain", lcd_datain, mem[m_id * 64 + age - 1]);
      end
      chk("rsp_valid", bus.rsp_valid, e_rv);
      chk("rsp_last", bus.rsp_last, e_rl);
      if (e_rv) begin
        chk("rsp_data", bus.rsp_data, e_rd);
        chk("rsp_id", bus.rsp_id, e_rid);
      end
      chk("err_timeout", err_timeout, e_tmo);
      chk("err_count", err_count, e_cnt);
      if (bus.rsp_valid) begin
        rq_d.push_back(bus.rsp_data); rq_id.push_back(bus.rsp_id); rq_l.push_back(bus.rsp_last);
      end
      // advance to next cycle
      e_rv = 0; e_rl = 0;
      if (m_active) begin
        age = cyc - m_issue;
        if (lcd_output_valid) begin
          m_pix++;
          e_rv = 1; e_rd = lcd_dataout; e_rid = m_id; e_rl = (m_pix == 16);
          if (m_pix > 16) e_cnt = 1;
        end
        if (age == TIMEOUT) begin
          e_tmo = 1; m_active = 0;
        end else if (age >= 2 && (!m_load || age >= 65) && !lcd_busy) begin
          if (m_pix != 16) e_cnt = 1;
          m_active = 0;
        end
      end
      if (gr) begin
        m_active = 1; m_issue = cyc; m_id = g; m_last = g; m_load = (cmdg == 3'd1); m_pix = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearq();
    rq_d.delete(); rq_id.delete(); rq_l.delete(); gq.delete();
  endtask

  task automatic issue(input int id, input logic [2:0] cmd);
    int n;
    bus.req_valid[id] = 1'b1;
    if (id == 0) bus.req_cmd0 = cmd; else bus.req_cmd1 = cmd;
    n = 0;
    do begin tick(); n++; end while (!acc_prev[id] && n < 1000);
    chk("accept", acc_prev[id], 1);
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin tick(); n++; end while ((m_active || lcd_busy) && n < 2000);
    chk("idle_wait", m_active || lcd_busy, 0);
    repeat (2) tick();
  endtask

  function automatic int count_bits(input bit q[$], input bit v);
    int c;
    c = 0;
    foreach (q[i]) if (q[i] == v) c++;
    return c;
  endfunction

  logic [7:0] zoom_exp [16] = '{8'd18, 8'd19, 8'd20, 8'd21, 8'd26, 8'd27, 8'd28, 8'd29,
                                8'd34, 8'd35, 8'd36, 8'd37, 8'd42, 8'd43, 8'd44, 8'd45};
  bit alt_exp [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    int n;
    logic [2:0] c;
    bus.req_valid = 2'b00; bus.req_cmd0 = 3'd0; bus.req_cmd1 = 3'd0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = 8'(i);
      mem[64 + i] = 8'($urandom);
    end
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Load from requester 0, then fit display of odd rows/cols.
    clearq();
    issue(0, 3'd1);
    wait_idle();
    chk("load_img0", eimg[0], 8'd0);
    chk("load_img30", eimg[30], 8'd30);
    chk("load_img63", eimg[63], 8'd63);
    chk("load_nrsp", rq_d.size(), 16);
    chk("load_rsp_first", rq_d[0], 8'd9);
    chk("load_rsp_last", rq_d[15], 8'd63);
    chk("load_id1_cnt", count_bits(rq_id, 1'b1), 0);
    chk("load_last_flag", rq_l[15], 1);
    chk("load_last_cnt", count_bits(rq_l, 1'b1), 1);

    // Zoom-in then display: 4x4 window at rows/cols 2..5.
    clearq();
    issue(0, 3'd2);
    wait_idle();
    issue(0, 3'd0);
    wait_idle();
    chk("zoom_nrsp", rq_d.size(), 32);
    for (int i = 0; i < 16; i++) begin
      chk("zoom_px", rq_d[i], zoom_exp[i]);
      chk("disp_px", rq_d[16 + i], zoom_exp[i]);
    end
    chk("zoom_last", rq_l[15], 1);
    chk("disp_last", rq_l[31], 1);

    // Both requesters held: grants alternate; last winner was 0.
    clearq();
    bus.req_cmd0 = 3'd4; bus.req_cmd1 = 3'd4;
    bus.req_valid = 2'b11;
    n = 0;
    while (gq.size() < 4 && n < 2000) begin tick(); n++; end
    bus.req_valid = 2'b00;
    wait_idle();
    chk("alt_ngrant", gq.size(), 4);
    for (int i = 0; i < 4; i++) chk("alt_order", gq[i], alt_exp[i]);
    chk("alt_id0_rsp", count_bits(rq_id, 1'b0), 32);
    chk("alt_id1_rsp", count_bits(rq_id, 1'b1), 32);

    // Engine hangs: timeout, then the next request is served once busy drops.
    clearq();
    emode = 1;
    issue(1, 3'd0);
    emode = 0;
    n = 0;
    while (err_timeout !== 1'b1 && n < 400) begin tick(); n++; end
    chk("tmo_latency", n, TIMEOUT);
    chk("tmo_nrsp", rq_d.size(), 0);
    issue(0, 3'd5);
    wait_idle();
    chk("post_tmo_nrsp", rq_d.size(), 16);
    chk("post_tmo_err_count", err_count, 0);
    chk("post_tmo_sticky", err_timeout, 1);

    // Short burst: 15 pixels.
    clearq();
    emode = 2;
    issue(0, 3'd3);
    wait_idle();
    emode = 0;
    chk("short_nrsp", rq_d.size(), 15);
    chk("short_last_cnt", count_bits(rq_l, 1'b1), 0);
    chk("short_err_count", err_count, 1);

    // Reset during LOAD byte 30, then a fit command completes normally.
    clearq();
    issue(1, 3'd1);
    repeat (30) tick();
    #1 reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_clr_tmo", err_timeout, 0);
    chk("rst_clr_cnt", err_count, 0);
    chk("rst_no_rsp", rq_d.size(), 0);
    issue(1, 3'd3);
    wait_idle();
    chk("after_rst_nrsp", rq_d.size(), 16);
    chk("after_rst_id1", count_bits(rq_id, 1'b1), 16);
    chk("after_rst_last", rq_l[15], 1);
    chk("after_rst_err", {err_timeout, err_count}, 2'b00);

    // Randomized traffic from both requesters.
    for (int r = 0; r < 3000; r++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (acc_prev[i] || !bus.req_valid[i]) begin
          bus.req_valid[i] = ($urandom % 3 == 0);
          c = 3'($urandom % 8);
          if (i == 0) bus.req_cmd0 = c; else bus.req_cmd1 = c;
        end else if ($urandom % 50 == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
    end
    bus.req_valid = 2'b00;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
